cla_fast_adder: RTL and testbench

- Parameterised N-bit two-level carry-lookahead adder computing i_a + i_b + i_c with carry out.
- Sum and carry-out are registered: one-cycle latency, async active-high reset.
- Serves as the fast adder primitive for the core's ALU and address-generation paths.
- Combinational depth is O(log) in block count rather than O(N) ripple.

---
 rtl/cla_pkg.sv | 48 ++++
 rtl/cla_fast_adder_block.sv | 43 ++++
 rtl/cla_fast_adder.sv | 86 ++++++++
 tb/tb_cla_fast_adder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and the lookahead carry helper for the
// two-level carry-lookahead adder.
//
// Contents:
//   CLA_BLOCKCOUNT, CLA_BITPERBLOCK, CLA_N : default adder geometry.
//   CLA_MAX_W                               : widest generate/propagate vector
//                                             the helper accepts. It bounds both
//                                             the bits per block and the block count.
//   cla_carry()                             : flat sum-of-products carry into position idx.
package cla_pkg;

    localparam int CLA_BLOCKCOUNT  = 8;
    localparam int CLA_BITPERBLOCK = 4;
    localparam int CLA_N           = CLA_BLOCKCOUNT * CLA_BITPERBLOCK;
    localparam int CLA_MAX_W       = 32;

    // Carry into position idx, given per-position generate/propagate and a carry-in:
    //   c[idx] = g[idx-1] | p[idx-1]&g[idx-2] | ... | p[idx-1]&...&p[0]&cin
    // Every product term is built independently, so the result is a two-level
    // AND/OR expression rather than a ripple chain. Callers pass a constant idx
    // and zero-pad g/p up to CLA_MAX_W. The padding bits are never selected.
    function automatic logic cla_carry(
        input logic [CLA_MAX_W-1:0] g,
        input logic [CLA_MAX_W-1:0] p,
        input logic                 cin,
        input int                   idx
    );
        logic carry;
        logic prod;
        // Term that carries cin all the way through positions 0..idx-1.
        carry = cin;
        for (int k = 0; k < CLA_MAX_W; k++) begin
            if (k < idx) carry = carry & p[k];
        end
        // Term generated at position j and propagated through j+1..idx-1.
        for (int j = 0; j < CLA_MAX_W; j++) begin
            if (j < idx) begin
                prod = g[j];
                for (int k = 0; k < CLA_MAX_W; k++) begin
                    if (k > j && k < idx) prod = prod & p[k];
                end
                carry = carry | prod;
            end
        end
        return carry;
    endfunction

endpackage

// File: rtl/cla_fast_adder_block.sv
// cla_block: one first-level lookahead unit of W bits.
//
// Ports:
//   a_i, b_i [W-1:0] : operand slices.
//   cin_i            : carry into bit 0 of this block. It comes from the second-level network.
//   s_o [W-1:0]      : sum slice.
//   g_o              : group generate. The block produces a carry-out with cin = 0.
//   p_o              : group propagate. The block passes cin straight through.
module cla_block
    import cla_pkg::*;
#(
    parameter int W = CLA_BITPERBLOCK
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o,
    output logic         g_o,
    output logic         p_o
);

    logic [W-1:0]         g;
    logic [W-1:0]         p;
    logic [W-1:0]         c;
    logic [CLA_MAX_W-1:0] g_pad;
    logic [CLA_MAX_W-1:0] p_pad;

    assign g     = a_i & b_i;
    assign p     = a_i ^ b_i;
    assign g_pad = CLA_MAX_W'(g);
    assign p_pad = CLA_MAX_W'(p);

    // Internal carries come directly from the block carry-in, not from a ripple chain.
    for (genvar i = 0; i < W; i++) begin : g_carry
        assign c[i] = cla_carry(g_pad, p_pad, cin_i, i);
    end

    assign s_o = p ^ c;
    // The group generate is the block carry-out when the carry-in is zero.
    assign g_o = cla_carry(g_pad, p_pad, 1'b0, W);
    assign p_o = &p;

endmodule

// File: rtl/cla_fast_adder.sv
// cla_fast_adder: N-bit two-level carry-lookahead adder with registered outputs.
// The registered result is {o_c, o_s} = i_a + i_b + i_c. The result appears one
// edge after the inputs are sampled, and a new operation starts every cycle.
//
// Ports:
//   i_clk        : rising-edge clock.
//   i_rst        : asynchronous active-high reset. It clears o_s and o_c.
//   i_a, i_b [N] : operands.
//   i_c          : carry in.
//   o_s [N]      : registered sum, modulo 2^N.
//   o_c          : registered carry out, which is bit N of the full sum.
module cla_fast_adder
    import cla_pkg::*;
#(
    parameter int BLOCKCOUNT  = CLA_BLOCKCOUNT,
    parameter int BITPERBLOCK = CLA_BITPERBLOCK,
    parameter int N           = CLA_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c,
    output logic [N-1:0] o_s,
    output logic         o_c
);

    if (N != BLOCKCOUNT * BITPERBLOCK) begin : g_bad_width
        $error("cla_fast_adder: N (%0d) must equal BLOCKCOUNT*BITPERBLOCK (%0d)",
               N, BLOCKCOUNT * BITPERBLOCK);
    end
    if (BLOCKCOUNT < 1 || BLOCKCOUNT > CLA_MAX_W ||
        BITPERBLOCK < 1 || BITPERBLOCK > CLA_MAX_W) begin : g_bad_geometry
        $error("cla_fast_adder: BLOCKCOUNT and BITPERBLOCK must be in 1..%0d", CLA_MAX_W);
    end

    logic [BLOCKCOUNT-1:0] blk_g;
    logic [BLOCKCOUNT-1:0] blk_p;
    logic [BLOCKCOUNT:0]   blk_c;
    logic [CLA_MAX_W-1:0]  blk_g_pad;
    logic [CLA_MAX_W-1:0]  blk_p_pad;

    logic [N-1:0] s_d;
    logic         c_d;
    logic [N-1:0] s_q;
    logic         c_q;

    for (genvar j = 0; j < BLOCKCOUNT; j++) begin : g_blk
        cla_block #(
            .W(BITPERBLOCK)
        ) u_blk (
            .a_i  (i_a[j*BITPERBLOCK +: BITPERBLOCK]),
            .b_i  (i_b[j*BITPERBLOCK +: BITPERBLOCK]),
            .cin_i(blk_c[j]),
            .s_o  (s_d[j*BITPERBLOCK +: BITPERBLOCK]),
            .g_o  (blk_g[j]),
            .p_o  (blk_p[j])
        );
    end

    assign blk_g_pad = CLA_MAX_W'(blk_g);
    assign blk_p_pad = CLA_MAX_W'(blk_p);

    // The second-level network applies the same lookahead expansion to the group
    // generate and propagate signals. Each block carry-in depends only on i_c and
    // the G/P signals, not on the carry-out of the previous block.
    for (genvar j = 0; j <= BLOCKCOUNT; j++) begin : g_blk_carry
        assign blk_c[j] = cla_carry(blk_g_pad, blk_p_pad, i_c, j);
    end

    assign c_d = blk_c[BLOCKCOUNT];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s_q <= '0;
            c_q <= 1'b0;
        end else begin
            s_q <= s_d;
            c_q <= c_d;
        end
    end

    assign o_s = s_q;
    assign o_c = c_q;

endmodule

// File: tb/tb_cla_fast_adder.sv
// Bench for cla_fast_adder. Two instances are driven from the same inputs:
// one with the default 8x4 geometry and one with a 4x8 geometry.
module tb_cla_fast_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s_8x4;
    logic         c_8x4;
    logic [W-1:0] s_4x8;
    logic         c_4x8;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    cla_fast_adder u_dut_8x4 (
        .i_clk(clk),
        .i_rst(rst),
        .i_a  (a),
        .i_b  (b),
        .i_c  (cin),
        .o_s  (s_8x4),
        .o_c  (c_8x4)
    );

    cla_fast_adder #(
        .BLOCKCOUNT (4),
        .BITPERBLOCK(8),
        .N          (32)
    ) u_dut_4x8 (
        .i_clk(clk),
        .i_rst(rst),
        .i_a  (a),
        .i_b  (b),
        .i_c  (cin),
        .o_s  (s_4x8),
        .o_c  (c_4x8)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got {c,s}=%h expected %h", tag, got, exp);
    endtask

    task automatic check_both(input string tag, input logic [W:0] exp);
        check({tag, "/8x4"}, {c_8x4, s_8x4}, exp);
        check({tag, "/4x8"}, {c_4x8, s_4x8}, exp);
    endtask

    // ---------------- drivers ----------------
    // Drive on the falling edge, then check 1 time unit after the next rising edge.
    task automatic run_vec(input string tag, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                           input logic c_v, input logic [W:0] exp);
        @(negedge clk);
        a   = a_v;
        b   = b_v;
        cin = c_v;
        @(posedge clk);
        #1;
        check_both(tag, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   rexp;

        rst = 1'b0;
        a   = 32'hDEADBEEF;
        b   = 32'h12345678;
        cin = 1'b1;
        // Assert reset well before the first clock edge at t=5.
        #1 rst = 1'b1;
        #1 check_both("rst_async", 33'h0);
        @(posedge clk);
        #1 check_both("rst_held", 33'h0);
        @(negedge clk);
        a   = '0;
        b   = '0;
        cin = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1 check_both("rst_release_zero", 33'h0);

        run_vec("3+8",          32'h00000003, 32'h00000008, 1'b0, 33'h0_0000000B);
        run_vec("3+8+1",        32'h00000003, 32'h00000008, 1'b1, 33'h0_0000000C);
        run_vec("5+8+1",        32'h00000005, 32'h00000008, 1'b1, 33'h0_0000000E);
        run_vec("fffffffe+1",   32'hFFFFFFFE, 32'h00000001, 1'b0, 33'h0_FFFFFFFF);
        run_vec("ffffffff+1+1", 32'hFFFFFFFF, 32'h00000001, 1'b1, 33'h1_00000001);
        run_vec("ffffffff+0+1", 32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000);
        run_vec("ffffffff+ff",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF);
        run_vec("alt_pattern",  32'hAAAAAAAA, 32'h55555555, 1'b0, 33'h0_FFFFFFFF);
        run_vec("alt_pattern_c",32'hAAAAAAAA, 32'h55555555, 1'b1, 33'h1_00000000);
        run_vec("80000000x2",   32'h80000000, 32'h80000000, 1'b0, 33'h1_00000000);
        run_vec("0x0f+1",       32'h0000000F, 32'h00000001, 1'b0, 33'h0_00000010);
        run_vec("0x0fffffff+1", 32'h0FFFFFFF, 32'h00000001, 1'b0, 33'h0_10000000);

        // Carry out of each 4-bit boundary: (2^(4k) - 1) + 1 = 2^(4k).
        for (int k = 1; k < 8; k++) begin
            run_vec($sformatf("boundary_%0d", 4 * k), (32'h1 << (4 * k)) - 32'h1,
                    32'h00000001, 1'b0, 33'h1 << (4 * k));
        end

        // Reset in the middle of a stream discards the pending result.
        run_vec("pre_midrst", 32'h12345678, 32'h11111111, 1'b0, 33'h0_23456789);
        @(negedge clk);
        a   = 32'h0000FFFF;
        b   = 32'h00000001;
        rst = 1'b1;
        #1 check_both("midrst_async", 33'h0);
        @(posedge clk);
        #1 check_both("midrst_held", 33'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check_both("midrst_first_edge", 33'h0_00010000);

        // Back-to-back random vectors, one per cycle.
        for (int i = 0; i < 40; i++) begin
            ra   = $urandom();
            rb   = $urandom();
            rc   = 1'($urandom_range(1, 0));
            rexp = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
            run_vec($sformatf("rand_%0d", i), ra, rb, rc, rexp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
